l2_port_arbiter: RTL
====================

# l2_port_arbiter

- Parametrised N-port round-robin arbiter that merges line-wide requests from several L1 caches (I-cache, D-cache, future prefetch/victim ports) onto one shared downstream line port (L2 cache or physical memory).
- Latches the winning request, holds the downstream handshake stable until `down_resp`, then returns the line to the granted port only.
- Supersedes the fixed two-port I/D arbitration with a generic channel count and fair rotation.

## Interface

Parameters:
- `N_PORTS`, 2: number of upstream channels (≥2).
- `s_line`, 256: line width in bits.
- `s_addr`, 32: address width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `up_read`  in  N_PORTS  per-port line read request, level, held until that port's `up_resp`.
- `up_write`  in  N_PORTS  per-port line write request, same rule.
- `up_address`  in  N_PORTS*s_addr  port i at bits [i*s_addr +: s_addr].
- `up_wdata`  in  N_PORTS*s_line  port i at bits [i*s_line +: s_line].
- `up_rdata`  out  s_line  returned line, shared by all ports; valid only with a `up_resp` bit.
- `up_resp`  out  N_PORTS  one-hot, one-cycle completion pulse.
- `down_read`  out  1  downstream read.
- `down_write`  out  1  downstream write.
- `down_address`  out  s_addr  downstream address.
- `down_wdata`  out  s_line  downstream write line.
- `down_rdata`  in  s_line  downstream read line, valid with `down_resp`.
- `down_resp`  in  1  downstream completion, one cycle.

## Operation

- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Port i requests when `up_read[i] | up_write[i]`.
  - If any port requests, pick the first requester searching from `last_grant+1` upward, modulo N_PORTS.
  - Latch grant index, address, wdata and op into registers; go to BUSY.
  - If both read and write are asserted on the winning port, latch a write.
- BUSY:
  - `down_read`/`down_write`/`down_address`/`down_wdata` are driven from the latched registers only, constant for the whole state.
  - On `down_resp`: capture `down_rdata` into the response register, set `last_grant` ← grant, go to RESP.
- RESP:
  - `up_resp[grant]`=1 and `up_rdata`=response register, for exactly one cycle.
  - Then go to IDLE.
- An upstream request that is withdrawn or changed while BUSY does not affect the transaction in flight; it completes and responds normally.
- Writes also pulse `up_resp`. `up_rdata` then carries whatever `down_rdata` held at `down_resp` and must be ignored.
- Non-granted ports see `up_resp`=0 throughout.
- Reset values: state IDLE, `last_grant`=N_PORTS-1 (so port 0 wins first), all outputs 0, response register 0.
- Reset mid-transaction: next cycle `down_read`=`down_write`=0 and state is IDLE. A pending `down_resp` is dropped. Downstream must tolerate the abandoned request.

## Timing

- Request first visible in IDLE at cycle t → `down_read`/`down_write` high from cycle t+1.
- `down_resp` at cycle t+1+k (k≥0) → `up_resp` at t+2+k. IDLE is re-entered at t+3+k.
- Minimum port-to-port turnaround: 3 cycles per transaction. No overlapping transactions.
- `down_*` control deasserts in the cycle after `down_resp`.
- A request arriving in the RESP cycle is arbitrated in the following IDLE cycle.
- `down_resp` outside BUSY is ignored.

## Configuration

- `L2_ARB_FASTRESP_EN`:
  - Defined: RESP state is removed. In the `down_resp` cycle, `up_resp[grant]`=1 and `up_rdata`=`down_rdata` combinationally, and the FSM goes straight to IDLE. Latency drops to t+1+k, turnaround to 2 cycles. The response register is not instantiated.
  - Undefined: registered behaviour as described above.

## Test plan

- Single read: port 0 reads 0x0000_1000; downstream returns 0xA5…A5 after k=3 → `down_read` from t+1, `up_resp`=2'b01 at t+5, `up_rdata`=0xA5…A5, `up_resp[1]` never set.
- Contention, N_PORTS=3: all ports request continuously from reset → grants in order 0,1,2,0. Each `up_resp` is one-hot; no port is served twice before the others.
- Mid-transaction change: port 1 write to 0x40 with wdata 0x11…11; at t+2 port 1 changes address to 0x80 → `down_address` stays 0x40 and `down_wdata` stays 0x11…11 until `down_resp`.
- Read+write together: port 0 asserts both → `down_write`=1, `down_read`=0.
- Reset mid-BUSY: `rst` pulsed at t+2 → at t+3 `down_read`=0, `up_resp`=0. A subsequent port-1 request is granted ahead of a simultaneous port-0 request? No: port 0 wins first after reset.
- Build with `L2_ARB_FASTRESP_EN`, k=0 → `up_resp` in the same cycle as `down_resp`, at t+1, and `up_rdata` equals `down_rdata` in that cycle.

Source files
------------

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter
//   N-port round-robin arbiter merging line-wide L1 requests (I$, D$,
//   prefetch/victim) onto one shared downstream line port.
//   A winner is latched in IDLE, the downstream handshake is held from
//   latched registers during BUSY, and the returned line is handed back
//   to the granted port only.
//
//   Optional feature macro: L2_ARB_FASTRESP_EN
//     defined   : no RESP state; up_resp/up_rdata are driven combinationally
//                 in the down_resp cycle, FSM returns directly to IDLE.
//     undefined : up_resp/up_rdata registered, one RESP cycle.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   up_read/up_write [N]      per-port level requests, held until up_resp
//   up_address [N*s_addr]     port i at [i*s_addr +: s_addr]
//   up_wdata   [N*s_line]     port i at [i*s_line +: s_line]
//   up_rdata   [s_line]       returned line (shared), valid with up_resp
//   up_resp    [N]            one-hot, one-cycle completion pulse
//   down_read/down_write      downstream op
//   down_address/down_wdata   downstream address / write line
//   down_rdata/down_resp      downstream read line and completion
module l2_port_arbiter #(
  parameter int N_PORTS = 2,
  parameter int s_line  = 256,
  parameter int s_addr  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PORTS-1:0]         up_read,
  input  logic [N_PORTS-1:0]         up_write,
  input  logic [N_PORTS*s_addr-1:0]  up_address,
  input  logic [N_PORTS*s_line-1:0]  up_wdata,
  output logic [s_line-1:0]          up_rdata,
  output logic [N_PORTS-1:0]         up_resp,
  output logic                       down_read,
  output logic                       down_write,
  output logic [s_addr-1:0]          down_address,
  output logic [s_line-1:0]          down_wdata,
  input  logic [s_line-1:0]          down_rdata,
  input  logic                       down_resp
);
  localparam int GW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              r_state;
  logic [GW-1:0]       r_last;
  logic [GW-1:0]       r_grant;
  logic [s_addr-1:0]   r_addr;
  logic [s_line-1:0]   r_wdata;
  logic                r_down_read;
  logic                r_down_write;
`ifndef L2_ARB_FASTRESP_EN
  logic [s_line-1:0]   r_rdata;
  logic [N_PORTS-1:0]  r_resp;
`endif

  logic [N_PORTS-1:0]  w_req;
  logic                w_found;
  logic [GW-1:0]       w_win;
  logic [N_PORTS-1:0]  w_grant_oh;

  assign w_req      = up_read | up_write;
  assign w_grant_oh = N_PORTS'(1) << r_grant;

  // Rotating priority: scan last+1, last+2, ... wrapping, first hit wins.
  // k runs to N_PORTS so the last winner is considered last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      if (!w_found && w_req[(int'(r_last) + k) % N_PORTS]) begin
        w_found = 1'b1;
        w_win   = GW'((int'(r_last) + k) % N_PORTS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last       <= GW'(N_PORTS - 1);
      r_grant      <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_down_read  <= 1'b0;
      r_down_write <= 1'b0;
`ifndef L2_ARB_FASTRESP_EN
      r_rdata      <= '0;
      r_resp       <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant      <= w_win;
            r_addr       <= up_address[w_win*s_addr +: s_addr];
            r_wdata      <= up_wdata[w_win*s_line +: s_line];
            // read+write together resolves to a write
            r_down_write <= up_write[w_win];
            r_down_read  <= ~up_write[w_win];
            r_state      <= BUSY;
          end
        end
        BUSY: begin
          if (down_resp) begin
            r_down_read  <= 1'b0;
            r_down_write <= 1'b0;
            r_last       <= r_grant;
`ifdef L2_ARB_FASTRESP_EN
            r_state      <= IDLE;
`else
            r_rdata      <= down_rdata;
            r_resp       <= w_grant_oh;
            r_state      <= RESP;
`endif
          end
        end
        RESP: begin
`ifndef L2_ARB_FASTRESP_EN
          r_resp  <= '0;
`endif
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign down_read    = r_down_read;
  assign down_write   = r_down_write;
  assign down_address = r_addr;
  assign down_wdata   = r_wdata;

`ifdef L2_ARB_FASTRESP_EN
  // Gated by BUSY so a stray down_resp never reaches a port.
  assign up_resp  = (r_state == BUSY && down_resp) ? w_grant_oh : '0;
  assign up_rdata = down_rdata;
`else
  assign up_resp  = r_resp;
  assign up_rdata = r_rdata;
`endif

endmodule
